ramctrl: RTL and testbench

RAMCTRL -- requirements
Module: ramctrl

---
 rtl/ramctrl_pkg.sv | 24 ++
 rtl/ramctrl.sv | 140 ++++++++++++++
 tb/tb_ramctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ramctrl_pkg.sv
// Shared constants and types for the byte-serial RAM controller.
// Holds the address/instruction widths and the load/store width encodings.
package ramctrl_pkg;

  localparam int unsigned AddressWidth = 32;
  localparam int unsigned IDWidth      = 32;

  // Load/store width field is a plain byte count.
  localparam logic [2:0] WIDTH_BYTE = 3'd1;
  localparam logic [2:0] WIDTH_HALF = 3'd2;
  localparam logic [2:0] WIDTH_WORD = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE
  } state_t;

  typedef enum logic {
    OWN_ICACHE,
    OWN_LSB
  } owner_t;

endpackage

// File: rtl/ramctrl.sv
// Byte-serial RAM controller arbitrating instruction fetches and load/store
// accesses onto an 8-bit memory port, with I/O write back-pressure.
module ramctrl
  import ramctrl_pkg::*;
#(
  parameter int unsigned              READ_LATENCY = 1,
  parameter logic [AddressWidth-1:0]  IO_BASE      = 32'h30000
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,

  input  logic                    icache_ramctrl_en_in,
  input  logic [AddressWidth-1:0] icache_ramctrl_addr_in,
  output logic                    ramctrl_icache_inst_rdy_out,
  output logic [IDWidth-1:0]      ramctrl_icache_inst_inst_out,

  input  logic                    lsb_ramctrl_en_in,
  input  logic                    lsb_ramctrl_rw_in,
  input  logic [2:0]              lsb_ramctrl_width_in,
  input  logic [AddressWidth-1:0] lsb_ramctrl_addr_in,
  input  logic [31:0]             lsb_ramctrl_data_in,
  output logic                    ramctrl_lsb_rdy_out,
  output logic [31:0]             ramctrl_lsb_data_out,

  input  logic [7:0]              mem_din_in,
  output logic [7:0]              mem_dout_out,
  output logic [AddressWidth-1:0] mem_a_out,
  output logic                    mem_wr_out,
  input  logic                    io_buffer_full_in
);

  state_t                  state;
  owner_t                  owner;
  logic [2:0]              cnt;
  logic [2:0]              width_q;
  logic [AddressWidth-1:0] base_q;
  logic [31:0]             data_q;
  logic [31:0]             rd_buf;
  logic                    wr_q;

  logic [31:0]             merged;
  logic [2:0]              cnt_nxt;
  logic [1:0]              idx_nxt;
  logic                    last;
  logic                    io_block;

  // The byte addressed in the current cycle is the final one of the access.
  assign last     = (cnt + 3'(READ_LATENCY)) == width_q;
  assign cnt_nxt  = cnt + 3'd1;
  assign idx_nxt  = cnt_nxt[1:0];
  assign io_block = wr_q & io_buffer_full_in & (mem_a_out >= IO_BASE);

  // Write strobe is the only output gated combinationally: a stalled I/O byte
  // or a frozen pipeline must never reach the memory as a write.
  assign mem_wr_out = wr_q & rdy_in & ~io_block;

  always_comb begin
    merged = rd_buf;
    merged[{cnt[1:0], 3'b000} +: 8] = mem_din_in;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state                        <= ST_IDLE;
      owner                        <= OWN_ICACHE;
      cnt                          <= '0;
      width_q                      <= '0;
      base_q                       <= '0;
      data_q                       <= '0;
      rd_buf                       <= '0;
      wr_q                         <= 1'b0;
      mem_a_out                    <= '0;
      mem_dout_out                 <= '0;
      ramctrl_icache_inst_rdy_out  <= 1'b0;
      ramctrl_icache_inst_inst_out <= '0;
      ramctrl_lsb_rdy_out          <= 1'b0;
      ramctrl_lsb_data_out         <= '0;
    end else if (rdy_in) begin
      ramctrl_icache_inst_rdy_out <= 1'b0;
      ramctrl_lsb_rdy_out         <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt    <= '0;
          rd_buf <= '0;
          if (lsb_ramctrl_en_in) begin
            owner        <= OWN_LSB;
            base_q       <= lsb_ramctrl_addr_in;
            width_q      <= lsb_ramctrl_width_in;
            data_q       <= lsb_ramctrl_data_in;
            mem_a_out    <= lsb_ramctrl_addr_in;
            mem_dout_out <= lsb_ramctrl_data_in[7:0];
            wr_q         <= lsb_ramctrl_rw_in;
            state        <= lsb_ramctrl_rw_in ? ST_WRITE : ST_READ;
          end else if (icache_ramctrl_en_in) begin
            owner     <= OWN_ICACHE;
            base_q    <= icache_ramctrl_addr_in;
            width_q   <= WIDTH_WORD;
            mem_a_out <= icache_ramctrl_addr_in;
            wr_q      <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          if (owner == OWN_ICACHE && !icache_ramctrl_en_in) begin
            state <= ST_IDLE;
          end else if (last) begin
            state <= ST_IDLE;
            if (owner == OWN_LSB) begin
              ramctrl_lsb_data_out <= merged;
              ramctrl_lsb_rdy_out  <= 1'b1;
            end else begin
              ramctrl_icache_inst_inst_out <= merged;
              ramctrl_icache_inst_rdy_out  <= 1'b1;
            end
          end else begin
            rd_buf    <= merged;
            cnt       <= cnt_nxt;
            mem_a_out <= base_q + AddressWidth'(cnt_nxt);
          end
        end
        ST_WRITE: begin
          if (!io_block) begin
            if (last) begin
              state               <= ST_IDLE;
              wr_q                <= 1'b0;
              ramctrl_lsb_rdy_out <= 1'b1;
            end else begin
              cnt          <= cnt_nxt;
              mem_a_out    <= base_q + AddressWidth'(cnt_nxt);
              mem_dout_out <= data_q[{idx_nxt, 3'b000} +: 8];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ramctrl.sv
// Scoreboard bench for ramctrl: expected readies and write bytes are queued
// when a request is issued and popped when the controller produces them.
module tb_ramctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        icache_ramctrl_en_in;
  logic [31:0] icache_ramctrl_addr_in;
  logic        ramctrl_icache_inst_rdy_out;
  logic [31:0] ramctrl_icache_inst_inst_out;
  logic        lsb_ramctrl_en_in;
  logic        lsb_ramctrl_rw_in;
  logic [2:0]  lsb_ramctrl_width_in;
  logic [31:0] lsb_ramctrl_addr_in;
  logic [31:0] lsb_ramctrl_data_in;
  logic        ramctrl_lsb_rdy_out;
  logic [31:0] ramctrl_lsb_data_out;
  logic [7:0]  mem_din_in;
  logic [7:0]  mem_dout_out;
  logic [31:0] mem_a_out;
  logic        mem_wr_out;
  logic        io_buffer_full_in;

  ramctrl #(.READ_LATENCY(1), .IO_BASE(32'h30000)) dut (
    .clk_in                       (clk_in),
    .rst_in                       (rst_in),
    .rdy_in                       (rdy_in),
    .icache_ramctrl_en_in         (icache_ramctrl_en_in),
    .icache_ramctrl_addr_in       (icache_ramctrl_addr_in),
    .ramctrl_icache_inst_rdy_out  (ramctrl_icache_inst_rdy_out),
    .ramctrl_icache_inst_inst_out (ramctrl_icache_inst_inst_out),
    .lsb_ramctrl_en_in            (lsb_ramctrl_en_in),
    .lsb_ramctrl_rw_in            (lsb_ramctrl_rw_in),
    .lsb_ramctrl_width_in         (lsb_ramctrl_width_in),
    .lsb_ramctrl_addr_in          (lsb_ramctrl_addr_in),
    .lsb_ramctrl_data_in          (lsb_ramctrl_data_in),
    .ramctrl_lsb_rdy_out          (ramctrl_lsb_rdy_out),
    .ramctrl_lsb_data_out         (ramctrl_lsb_data_out),
    .mem_din_in                   (mem_din_in),
    .mem_dout_out                 (mem_dout_out),
    .mem_a_out                    (mem_a_out),
    .mem_wr_out                   (mem_wr_out),
    .io_buffer_full_in            (io_buffer_full_in)
  );

  always #5 clk_in = ~clk_in;

  int unsigned cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int unsigned cyc;
    bit          rd;
  } rdy_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int unsigned cyc;
  } wr_exp_t;

  rdy_exp_t lsb_q[$];
  rdy_exp_t ic_q[$];
  wr_exp_t  wr_q[$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Scenario hooks evaluated by the runner at every falling edge.
  int unsigned io_release = 0;
  int unsigned frz_lo     = 0;
  int unsigned frz_hi     = 0;
  int unsigned ic_drop    = 32'hFFFF_FFFF;
  int unsigned a_lo       = 0;
  int unsigned a_hi       = 0;
  logic [31:0] a_base     = '0;

  logic [7:0] ram [logic [31:0]];

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    if (ram.exists(a)) return ram[a];
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a, input int unsigned w);
    logic [31:0] r;
    r = '0;
    for (int unsigned k = 0; k < w; k++) r[8*k +: 8] = ram_rd(a + k);
    return r;
  endfunction

  // Memory with a one-cycle address-to-data path.
  always @(posedge clk_in) begin
    if (mem_wr_out) ram[mem_a_out] = mem_dout_out;
    #1 mem_din_in = ram_rd(mem_a_out);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic chk_cleared(input string p);
    chk({p, "_wr"},    32'(mem_wr_out), 0);
    chk({p, "_a"},     mem_a_out, 0);
    chk({p, "_dout"},  32'(mem_dout_out), 0);
    chk({p, "_icrdy"}, 32'(ramctrl_icache_inst_rdy_out), 0);
    chk({p, "_inst"},  ramctrl_icache_inst_inst_out, 0);
    chk({p, "_lsrdy"}, 32'(ramctrl_lsb_rdy_out), 0);
    chk({p, "_ldata"}, ramctrl_lsb_data_out, 0);
  endtask

  task automatic run(input int unsigned n);
    rdy_exp_t e;
    wr_exp_t  w;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk_in);
      io_buffer_full_in = (cyc < io_release);
      rdy_in = !((cyc >= frz_lo) && (cyc < frz_hi));
      if (cyc == ic_drop) icache_ramctrl_en_in = 1'b0;
      #1;
      if (ramctrl_lsb_rdy_out) begin
        if (lsb_q.size() == 0) chk("lsb_unexpected_rdy", 1, 0);
        else begin
          e = lsb_q.pop_front();
          chk("lsb_rdy_cyc", cyc, e.cyc);
          if (e.rd) chk("lsb_data", ramctrl_lsb_data_out, e.data);
        end
        lsb_ramctrl_en_in = 1'b0;
      end
      if (ramctrl_icache_inst_rdy_out) begin
        if (ic_q.size() == 0) chk("ic_unexpected_rdy", 1, 0);
        else begin
          e = ic_q.pop_front();
          chk("ic_rdy_cyc", cyc, e.cyc);
          chk("ic_inst", ramctrl_icache_inst_inst_out, e.data);
        end
        icache_ramctrl_en_in = 1'b0;
      end
      if (mem_wr_out) begin
        if (wr_q.size() == 0) chk("unexpected_write", mem_a_out, 32'hFFFF_FFFF);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", mem_a_out, w.addr);
          chk("wr_data", 32'(mem_dout_out), 32'(w.data));
          chk("wr_cyc",  cyc, w.cyc);
        end
      end
      if (cyc >= a_lo && cyc < a_hi) chk("fetch_addr", mem_a_out, a_base + (cyc - a_lo));
    end
  endtask

  task automatic drained(input string p);
    chk({p, "_lsb_pending"}, lsb_q.size(), 0);
    chk({p, "_ic_pending"},  ic_q.size(), 0);
    chk({p, "_wr_pending"},  wr_q.size(), 0);
    lsb_q.delete(); ic_q.delete(); wr_q.delete();
    io_release = 0; frz_lo = 0; frz_hi = 0; ic_drop = 32'hFFFF_FFFF; a_lo = 0; a_hi = 0;
  endtask

  task automatic lsb_issue(input logic rw, input logic [2:0] w, input logic [31:0] a, input logic [31:0] d);
    lsb_ramctrl_en_in    = 1'b1;
    lsb_ramctrl_rw_in    = rw;
    lsb_ramctrl_width_in = w;
    lsb_ramctrl_addr_in  = a;
    lsb_ramctrl_data_in  = d;
  endtask

  int unsigned c;

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full_in = 1'b0;
    icache_ramctrl_en_in = 1'b0; icache_ramctrl_addr_in = '0;
    lsb_ramctrl_en_in = 1'b0; lsb_ramctrl_rw_in = 1'b0; lsb_ramctrl_width_in = 3'd1;
    lsb_ramctrl_addr_in = '0; lsb_ramctrl_data_in = '0;
    ram[32'h1004] = 8'h13; ram[32'h1005] = 8'h05; ram[32'h1006] = 8'h00; ram[32'h1007] = 8'h00;

    repeat (2) @(negedge clk_in);
    #1 chk_cleared("reset");
    @(negedge clk_in) rst_in = 1'b0;
    run(2);

    // Instruction fetch of a known word.
    @(negedge clk_in);
    c = cyc;
    icache_ramctrl_en_in = 1'b1; icache_ramctrl_addr_in = 32'h1004;
    ic_q.push_back('{32'h0000_0513, c + 5, 1'b1});
    a_lo = c + 1; a_hi = c + 5; a_base = 32'h1004;
    run(7);
    chk("a_hold_idle", mem_a_out, 32'h1007);
    drained("fetch");

    // Simultaneous requests: load first, fetch accepted after its ready.
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b0, 3'd2, 32'h1003, '0);
    icache_ramctrl_en_in = 1'b1; icache_ramctrl_addr_in = 32'h2000;
    lsb_q.push_back('{exp_read(32'h1003, 2), c + 3, 1'b1});
    ic_q.push_back('{exp_read(32'h2000, 4), c + 8, 1'b1});
    run(10);
    drained("both");

    // Halfword store, then read it back.
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b1, 3'd2, 32'h200, 32'h0000_BEEF);
    wr_q.push_back('{32'h200, 8'hEF, c + 1});
    wr_q.push_back('{32'h201, 8'hBE, c + 2});
    lsb_q.push_back('{'0, c + 3, 1'b0});
    run(5);
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b0, 3'd2, 32'h200, '0);
    lsb_q.push_back('{32'h0000_BEEF, c + 3, 1'b1});
    run(5);
    drained("half");

    // Byte store to I/O space held off by a full buffer.
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b1, 3'd1, 32'h30000, 32'hA5A5_A55A);
    io_buffer_full_in = 1'b1; io_release = c + 4;
    wr_q.push_back('{32'h30000, 8'h5A, c + 4});
    lsb_q.push_back('{'0, c + 5, 1'b0});
    run(8);
    drained("io");

    // Fetch withdrawn mid-access, then a byte load.
    @(negedge clk_in);
    c = cyc;
    icache_ramctrl_en_in = 1'b1; icache_ramctrl_addr_in = 32'h2000;
    ic_drop = c + 2;
    run(8);
    chk("inst_hold", ramctrl_icache_inst_inst_out, exp_read(32'h2000, 4));
    drained("abort");
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b0, 3'd1, 32'h2001, '0);
    lsb_q.push_back('{exp_read(32'h2001, 1), c + 2, 1'b1});
    run(4);
    drained("byte_ld");

    // Word load with a two-cycle global stall.
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b0, 3'd4, 32'h1004, '0);
    frz_lo = c + 2; frz_hi = c + 4;
    lsb_q.push_back('{32'h0000_0513, c + 7, 1'b1});
    run(9);
    drained("freeze");

    // Reset in the middle of a word store drops the rest of it.
    @(negedge clk_in);
    c = cyc;
    lsb_issue(1'b1, 3'd4, 32'h400, 32'h1122_3344);
    wr_q.push_back('{32'h400, 8'h44, c + 1});
    wr_q.push_back('{32'h401, 8'h33, c + 2});
    run(2);
    @(negedge clk_in);
    rst_in = 1'b1; lsb_ramctrl_en_in = 1'b0;
    #1 chk_cleared("midreset");
    @(negedge clk_in) rst_in = 1'b0;
    run(5);
    chk("ram_402_untouched", 32'(ram_rd(32'h402)), 32'(8'h02 ^ 8'h5A));
    drained("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
